ula_ctrl: RTL and testbench

ULA_CTRL -- requirements
Module: ula_ctrl

---
 rtl/ula_ctrl_pkg.sv | 40 ++++
 rtl/ula_ctrl_regfile.sv | 41 ++++
 rtl/ula_ctrl.sv | 130 +++++++++++++
 tb/tb_ula_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_ctrl_pkg.sv
// Shared definitions for the ALU controller: opcodes / ALU select codes,
// controller state encoding and small decode helpers.
package ula_ctrl_pkg;

  // Width of the register-address fields ra/rb inside the instruction byte.
  localparam int RA_W = 2;

  // The 4-bit opcode doubles as the ALU select code: the controller forwards
  // opcode[3:0] unchanged on alu_sel, and the ALU decodes the same values.
  typedef enum logic [3:0] {
    OP_NOT  = 4'h0,
    OP_AND  = 4'h1,
    OP_OR   = 4'h2,
    OP_XOR  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_MUL  = 4'h8,
    OP_ROL  = 4'h9,
    OP_LOAD = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // True for every opcode that is executed by the external ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_ROL;
  endfunction

  // True for the immediate-load opcode.
  function automatic logic is_load_op(input logic [3:0] op);
    return op == OP_LOAD;
  endfunction

endpackage

// File: rtl/ula_ctrl_regfile.sv
// Register file: NREGS x DW, two combinational read ports, one synchronous
// write port, synchronous active-high clear to zero.
module ula_ctrl_regfile
  import ula_ctrl_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [RA_W-1:0] raddr_a,
  input  logic [RA_W-1:0] raddr_b,
  output logic [DW-1:0]   rdata_a,
  output logic [DW-1:0]   rdata_b
);

  logic [DW-1:0] regs [NREGS];

  // Storage update: reset clears every register, otherwise one write per cycle.
  // NOTE: the array is cleared on reset because software relies on R[i]=0 after
  // reset; this keeps it in flops rather than a RAM macro, which is fine at 4x8.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: non-blocking even inside the loop, so every read of regs in
        // this clock sees the pre-edge value regardless of block ordering.
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational reads return the stored (pre-write) value in the write cycle.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/ula_ctrl.sv
// ALU controller: accepts one instruction at a time over a valid/ready
// handshake, feeds operands to an external ALU, and writes results back.
module ula_ctrl
  import ula_ctrl_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [7:0]    instr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_s,
  output logic          result_valid,
  output logic [DW-1:0] result,
  output logic          illegal
);

  // Instruction fields as offered on the input bus.
  logic [3:0]      op_in;
  logic [RA_W-1:0] ra_in;
  logic [RA_W-1:0] rb_in;

  assign op_in = instr[7:4];
  assign ra_in = instr[3:2];
  assign rb_in = instr[1:0];

  state_e          state;
  logic [RA_W-1:0] ra_q;        // destination of the instruction in flight
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [3:0]      alu_sel_q;
  logic [DW-1:0]   result_q;    // ALU capture or latched LOAD operand
  logic            rv_q;
  logic            illegal_q;

  logic [DW-1:0]   rd_a;
  logic [DW-1:0]   rd_b;
  logic            wr_en;
  logic            transfer;

  // Ready only when idle and not being reset, so a transfer can never race rst.
  assign instr_ready = (state == ST_IDLE) && !rst;
  assign transfer    = instr_valid && instr_ready;

  // Write-back happens on the edge that closes WB; a reset on that edge wins.
  assign wr_en = (state == ST_WB) && !rst;

  ula_ctrl_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .waddr   (ra_q),
    .wdata   (result_q),
    .raddr_a (ra_in),
    .raddr_b (rb_in),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Controller FSM with registered ALU operands, result and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ra_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      rv_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            ra_q <= ra_in;
            if (is_alu_op(op_in)) begin
              // Operands are read now, so ra==rb sees one pre-write value.
              alu_a_q   <= rd_a;
              alu_b_q   <= rd_b;
              alu_sel_q <= op_in;
              state     <= ST_EXEC;
            end else if (is_load_op(op_in)) begin
              result_q <= data_in;
              rv_q     <= 1'b1;
              state    <= ST_WB;
            end else begin
              // Undefined opcode: flag it and stay idle without any write.
              illegal_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          result_q  <= alu_s;
          rv_q      <= 1'b1;
          alu_a_q   <= '0;
          alu_b_q   <= '0;
          alu_sel_q <= '0;
          state     <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign result  = result_q;
  assign illegal = illegal_q;

  // A reset arriving during WB aborts the write, so the pulse is withdrawn too.
  assign result_valid = rv_q && !rst;

endmodule

// File: tb/tb_ula_ctrl.sv
// Self-checking bench for ula_ctrl with a behavioural ALU and register model.
module tb_ula_ctrl;
  import ula_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] data_in;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_s;
  logic       result_valid;
  logic [7:0] result;
  logic       illegal;

  int total  = 0;
  int passed = 0;

  // Reference state: architectural registers and last written value.
  logic [7:0] mreg [4];
  logic [7:0] mresult;

  always #5 clk = ~clk;

  ula_ctrl #(.NREGS(4), .DW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .data_in      (data_in),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_s        (alu_s),
    .result_valid (result_valid),
    .result       (result),
    .illegal      (illegal)
  );

  // Behavioural ALU: 8-bit wrap-around, shifts/rotate by b[2:0].
  function automatic logic [7:0] alu_fn(input logic [3:0] sel, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] w;
    case (sel)
      OP_NOT: return ~a;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_SHL: return a << b[2:0];
      OP_SHR: return a >> b[2:0];
      OP_MUL: return 8'(a * b);
      OP_ROL: begin
        w = {a, a} << b[2:0];
        return w[15:8];
      end
      default: return 8'h00;
    endcase
  endfunction

  assign alu_s = alu_fn(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at posedge+1 while idle: registers, held result, no stray pulses.
  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_r%0d", tag, i), dut.u_regfile.regs[i], mreg[i]);
    check({tag, "_result"}, result, mresult);
    check({tag, "_rv"}, result_valid, 1'b0);
    check({tag, "_illegal"}, illegal, 1'b0);
  endtask

  // Issue one instruction from idle (entered and left at posedge+1).
  task automatic do_op(input logic [7:0] ins, input logic [7:0] d);
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] exp;
    op = ins[7:4];
    ra = ins[3:2];
    rb = ins[1:0];
    instr_valid = 1'b1;
    instr       = ins;
    data_in     = d;
    @(negedge clk);
    check($sformatf("ready_%02h", ins), instr_ready, 1'b1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 8'($urandom);
    data_in     = 8'($urandom);
    @(negedge clk);
    if (op == 4'hF) begin
      check($sformatf("load_rv_%02h", ins), result_valid, 1'b1);
      check($sformatf("load_res_%02h", ins), result, d);
      check($sformatf("load_ready_%02h", ins), instr_ready, 1'b0);
      mreg[ra] = d;
      mresult  = d;
    end else if (op <= 4'd9) begin
      exp = alu_fn(op, mreg[ra], mreg[rb]);
      check($sformatf("exec_rv_%02h", ins), result_valid, 1'b0);
      check($sformatf("exec_ready_%02h", ins), instr_ready, 1'b0);
      check($sformatf("exec_a_%02h", ins), alu_a, mreg[ra]);
      check($sformatf("exec_b_%02h", ins), alu_b, mreg[rb]);
      check($sformatf("exec_sel_%02h", ins), alu_sel, op);
      check($sformatf("exec_hold_%02h", ins), result, mresult);
      @(negedge clk);
      check($sformatf("wb_rv_%02h", ins), result_valid, 1'b1);
      check($sformatf("wb_res_%02h", ins), result, exp);
      check($sformatf("wb_sel_%02h", ins), alu_sel, 4'h0);
      check($sformatf("wb_a_%02h", ins), alu_a, 8'h00);
      mreg[ra] = exp;
      mresult  = exp;
    end else begin
      check($sformatf("ill_pulse_%02h", ins), illegal, 1'b1);
      check($sformatf("ill_rv_%02h", ins), result_valid, 1'b0);
      check($sformatf("ill_ready_%02h", ins), instr_ready, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] pend_exp;
    logic [1:0] pend_ra;
    logic       pend;
    logic       exp_rv;
    int         pulse_cycle;
    int         free_at;
    logic [7:0] ins;

    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    data_in     = 8'h00;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mresult = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", instr_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1'b1);
    check("post_rst_alu_a", alu_a, 8'h00);
    check("post_rst_alu_b", alu_b, 8'h00);
    check("post_rst_sel", alu_sel, 4'h0);
    @(posedge clk);
    #1;
    check_regs("post_rst");

    // LOAD R1<-05, LOAD R2<-03, ADD R1,R2 -> 08
    do_op(8'hF4, 8'h05);
    do_op(8'hF8, 8'h03);
    do_op(8'h46, 8'h00);
    check("add_r1_lit", dut.u_regfile.regs[1], 8'h08);
    check("add_result_lit", result, 8'h08);
    check_regs("add");

    // SUB wraps, MUL truncates
    do_op(8'hF4, 8'h03);
    do_op(8'hF8, 8'h05);
    do_op(8'h56, 8'h00);
    check("sub_lit", result, 8'hFE);
    do_op(8'hF4, 8'h10);
    do_op(8'hF8, 8'h20);
    do_op(8'h86, 8'h00);
    check("mul_lit", result, 8'h00);
    check_regs("mul");

    // ROL, NOT, XOR with ra==rb
    do_op(8'hFC, 8'h81);
    do_op(8'hF0, 8'h01);
    do_op(8'h9C, 8'h00);
    check("rol_lit", dut.u_regfile.regs[3], 8'h03);
    do_op(8'hFC, 8'h81);
    do_op(8'h0C, 8'h00);
    check("not_lit", result, 8'h7E);
    do_op(8'h3F, 8'h00);
    check("xor_self_lit", dut.u_regfile.regs[3], 8'h00);
    check_regs("logic");

    // Illegal opcode: pulse only, no write
    do_op(8'hA0, 8'h77);
    check_regs("illegal");
    check("ill_ready_back", instr_ready, 1'b1);

    // Valid held high with changing instr: only idle-cycle instr executes
    free_at = 0;
    pend    = 1'b0;
    pulse_cycle = -1;
    for (int c = 0; c < 12; c++) begin
      seq         = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
      instr_valid = (c < 10);
      instr       = seq;
      data_in     = 8'($urandom);
      @(negedge clk);
      exp_rv = pend && (c == pulse_cycle);
      check($sformatf("seq_rv_c%0d", c), result_valid, exp_rv);
      if (exp_rv) begin
        check($sformatf("seq_res_c%0d", c), result, pend_exp);
        mreg[pend_ra] = pend_exp;
        mresult       = pend_exp;
        pend          = 1'b0;
      end
      check($sformatf("seq_ready_c%0d", c), instr_ready, (c >= free_at));
      if (c >= free_at && c < 10) begin
        pend_exp    = alu_fn(seq[7:4], mreg[seq[3:2]], mreg[seq[1:0]]);
        pend_ra     = seq[3:2];
        pend        = 1'b1;
        pulse_cycle = c + 2;
        free_at     = c + 3;
      end
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    check_regs("seq");

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      ins = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ins[7:4] = 4'hF;
      do_op(ins, 8'($urandom));
      check_regs($sformatf("rnd%0d", n));
    end

    // Reset has priority over a simultaneous transfer
    rst         = 1'b1;
    instr_valid = 1'b1;
    instr       = 8'hF4;
    data_in     = 8'h55;
    @(negedge clk);
    check("rst_prio_ready", instr_ready, 1'b0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mresult = 8'h00;
    @(negedge clk);
    check("rst_prio_rv", result_valid, 1'b0);
    check("rst_prio_ready_after", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    check_regs("rst_prio");

    // Reset during EXEC of ADD aborts the instruction
    do_op(8'hF4, 8'h05);
    do_op(8'hF8, 8'h03);
    instr_valid = 1'b1;
    instr       = 8'h46;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    check("rst_exec_rv", result_valid, 1'b0);
    check("rst_exec_ready", instr_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mresult = 8'h00;
    @(negedge clk);
    check("rst_exec_rv_after", result_valid, 1'b0);
    check("rst_exec_ready_after", instr_ready, 1'b1);
    @(posedge clk);
    #1;
    check_regs("rst_exec");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
